// File: rtl/riscv_isa_pkg.sv
// RV32I opcode and encoder error-code definitions shared by the decoder and the encoder.
package riscv_isa_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] ERR_OPCODE = 2'd0;
    localparam logic [1:0] ERR_RANGE  = 2'd1;
    localparam logic [1:0] ERR_ODD    = 2'd2;

    typedef enum logic {S_IDLE, S_RUN} enc_state_e;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
        logic [1:0]  code;
    } enc_result_t;

    // Field placement mirrors the decoder; the odd-immediate check outranks the range check.
    function automatic enc_result_t encode(input logic [6:0]  op,
                                           input logic [2:0]  f3,
                                           input logic [6:0]  f7,
                                           input logic [4:0]  ra,
                                           input logic [4:0]  rb,
                                           input logic [4:0]  rw,
                                           input logic [31:0] imm);
        enc_result_t r;
        r.word = '0;
        r.err  = 1'b0;
        r.code = ERR_OPCODE;
        case (op)
            OP_R: r.word = {f7, rb, ra, f3, rw, op};
            OP_LOAD: begin
                r.word = {imm[11:0], rb, f3, rw, op};
                r.err  = |imm[31:12];
                r.code = ERR_RANGE;
            end
            OP_ADDI, OP_JALR: begin
                r.word = {imm[11:0], ra, f3, rw, op};
                r.err  = |imm[31:12];
                r.code = ERR_RANGE;
            end
            OP_S: begin
                r.word = {imm[11:5], rb, ra, f3, imm[4:0], op};
                r.err  = |imm[31:12];
                r.code = ERR_RANGE;
            end
            OP_B: begin
                r.word = {imm[12], imm[10:5], rb, ra, f3, imm[4:1], imm[11], op};
                r.err  = imm[0] | (|imm[31:13]);
                r.code = imm[0] ? ERR_ODD : ERR_RANGE;
            end
            OP_JAL: begin
                r.word = {imm[20], imm[10:1], imm[11], imm[19:12], rw, op};
                r.err  = imm[0] | (|imm[31:21]);
                r.code = imm[0] ? ERR_ODD : ERR_RANGE;
            end
            OP_AUIPC: begin
                r.word = {imm[31:12], rw, op};
                r.err  = |imm[11:0];
                r.code = ERR_RANGE;
            end
            default: begin
                r.err  = 1'b1;
                r.code = ERR_OPCODE;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_word_fifo.sv
// Synchronous FIFO holding encoded instruction words ahead of the memory write port.
module instr_word_fifo import riscv_isa_pkg::*; #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             push, pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words and streams them to instruction memory.
module instr_encoder import riscv_isa_pkg::*; #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_ra,
    input  logic [4:0]        in_rb,
    input  logic [4:0]        in_rw,
    input  logic [31:0]       in_imm,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic              busy
);

    enc_state_e        state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              err_valid_q;
    logic [1:0]        err_code_q;

    enc_result_t enc;
    logic        accept, push, pop;
    logic        fifo_full, fifo_empty;
    logic [31:0] fifo_rdata;

    assign enc    = encode(in_opcode, in_funct3, in_funct7, in_ra, in_rb, in_rw, in_imm);
    assign accept = in_valid && in_ready;
    assign push   = accept && !enc.err;
    assign pop    = mem_valid && mem_ready;

    instr_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .wdata_i (enc.word),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready  = (state_q == S_RUN) && !fifo_full;
    assign mem_valid = !fifo_empty;
    assign mem_addr  = ptr_q;
    assign mem_wdata = fifo_empty ? '0 : fifo_rdata;
    assign busy      = (state_q == S_RUN) && !fifo_empty;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            err_valid_q <= accept && enc.err;
            if (accept && enc.err) begin
                err_code_q <= enc.code;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        ptr_q   <= base_addr;
                    end
                end
                S_RUN: begin
                    // A restart needs an empty FIFO, so it can never coincide with a pop.
                    if (start && fifo_empty && !accept) begin
                        ptr_q <= base_addr;
                    end else if (pop) begin
                        ptr_q <= ptr_q + ADDR_W'(4);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with a write scoreboard on the memory port.
module tb_instr_encoder;
    import riscv_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_ra, in_rb, in_rw;
    logic [31:0] in_imm;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        err_valid;
    logic [1:0]  err_code;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;
    logic [31:0] model_ptr;

    instr_encoder #(
        .FIFO_DEPTH (2),
        .ADDR_W     (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_ra     (in_ra),
        .in_rb     (in_rb),
        .in_rw     (in_rw),
        .in_imm    (in_imm),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .err_valid (err_valid),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                              input logic [31:0] imm);
        in_opcode = op;
        in_funct3 = f3;
        in_funct7 = f7;
        in_ra     = ra;
        in_rb     = rb;
        in_rw     = rw;
        in_imm    = imm;
    endtask

    // Returns #1 after the accepting edge.
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                        input logic [31:0] imm);
        bit done = 0;
        set_fields(op, f3, f7, ra, rb, rw, imm);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_word(input logic [31:0] data);
        exp_q.push_back({model_ptr, data});
        model_ptr = model_ptr + 32'd4;
    endtask

    task automatic pulse_start(input logic [31:0] a);
        start     = 1'b1;
        base_addr = a;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (!mem_valid) done = 1;
            else tick(1);
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_err(input string tag, input logic [1:0] code);
        check({tag, "_pulse"}, {31'd0, err_valid}, 32'd1);
        check({tag, "_code"}, {30'd0, err_code}, {30'd0, code});
        tick(1);
        check({tag, "_clear"}, {31'd0, err_valid}, 32'd0);
        check({tag, "_hold"}, {30'd0, err_code}, {30'd0, code});
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_valid && mem_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_addr", mem_addr, exp_e[63:32]);
                check("wr_data", mem_wdata, exp_e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        mem_ready = 1'b0;
        model_ptr = '0;
        set_fields('0, '0, '0, '0, '0, '0, '0);
        @(posedge clk);
        #1;
        tick(1);
        rst_n = 1'b1;

        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_err_valid", {31'd0, err_valid}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        tick(1);
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);

        mem_ready = 1'b1;
        pulse_start(32'h100);
        model_ptr = 32'h100;
        check("run_in_ready", {31'd0, in_ready}, 32'd1);

        expect_word(32'h00C0_8293);
        send(OP_ADDI, 3'd0, 7'd0, 5'd1, 5'd0, 5'd5, 32'd12);
        check("lat_mem_valid", {31'd0, mem_valid}, 32'd1);
        check("lat_mem_wdata", mem_wdata, 32'h00C0_8293);
        check("lat_mem_addr", mem_addr, 32'h100);
        check("ok_no_err", {31'd0, err_valid}, 32'd0);

        expect_word(32'h0020_81B3);
        send(OP_R, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
        expect_word(32'h4020_81B3);
        send(OP_R, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0);
        expect_word(32'h0081_2303);
        send(OP_LOAD, 3'd2, 7'd0, 5'd0, 5'd2, 5'd6, 32'd8);
        expect_word(32'h0020_8463);
        send(OP_B, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
        expect_word(32'h0010_00EF);
        send(OP_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
        expect_word(32'h0220_A223);
        send(OP_S, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'h24);
        expect_word(32'h1234_5397);
        send(OP_AUIPC, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7, 32'h1234_5000);

        send(OP_B, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd7);
        check_err("b_odd", ERR_ODD);
        send(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        check_err("bad_op", ERR_OPCODE);
        send(OP_ADDI, 3'd0, 7'd0, 5'd1, 5'd0, 5'd5, 32'h1000);
        check_err("i_range", ERR_RANGE);
        send(OP_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h0020_0001);
        check_err("j_odd_prio", ERR_ODD);
        send(OP_AUIPC, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7, 32'h123);
        check_err("u_range", ERR_RANGE);
        wait_drain();

        mem_ready = 1'b0;
        expect_word(32'h0020_81B3);
        send(OP_R, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
        expect_word(32'h0081_2303);
        send(OP_LOAD, 3'd2, 7'd0, 5'd0, 5'd2, 5'd6, 32'd8);
        set_fields(OP_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
        in_valid = 1'b1;
        tick(2);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_hold_wdata", mem_wdata, 32'h0020_81B3);
        check("full_busy", {31'd0, busy}, 32'd1);
        pulse_start(32'h800);
        check("ignored_start_addr", mem_addr, model_ptr - 32'd8);
        mem_ready = 1'b1;
        expect_word(32'h0010_00EF);
        send(OP_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
        wait_drain();

        pulse_start(32'h200);
        model_ptr = 32'h200;
        expect_word(32'h00C0_8293);
        send(OP_ADDI, 3'd0, 7'd0, 5'd1, 5'd0, 5'd5, 32'd12);
        wait_drain();

        mem_ready = 1'b0;
        send(OP_R, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
        send(OP_LOAD, 3'd2, 7'd0, 5'd0, 5'd2, 5'd6, 32'd8);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("mid_rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        tick(1);
        check("mid_rst_idle", {31'd0, in_ready}, 32'd0);

        mem_ready = 1'b1;
        pulse_start(32'hFFFF_FFFC);
        model_ptr = 32'hFFFF_FFFC;
        expect_word(32'h00C0_8293);
        send(OP_ADDI, 3'd0, 7'd0, 5'd1, 5'd0, 5'd5, 32'd12);
        expect_word(32'h0020_81B3);
        send(OP_R, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
        wait_drain();
        tick(2);
        check("pending_writes", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decode/immediate-generation stage: it takes decoded fields (opcode, funct3/funct7, Ra, Rb, Rw, immediate) and packs them into a 32-bit RV32I instruction word.
- Each word is written sequentially into instruction memory through a valid/ready write port.
- Used by the test/program loader to build programs for the processor without hand-assembling hex.
- Field placement matches the decoder exactly, so decode(encode(x)) returns the same fields.

Parameters:
- FIFO_DEPTH, 2, number of encoded words buffered between the encoder and the memory port; power of 2, ≥2.
- ADDR_W, 32, byte-address width of the memory port.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  pulse; loads base_addr into the write pointer and enters RUN.
- base_addr  in  ADDR_W  first byte address; must be word-aligned.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept the bundle.
- in_opcode  in  7  RV32I opcode.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R-type only).
- in_ra  in  5  Ra.
- in_rb  in  5  Rb.
- in_rw  in  5  Rw.
- in_imm  in  32  immediate, unshifted, zero-extended as produced by the decoder.
- mem_valid  out  1  write request.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  byte address of the write.
- mem_wdata  out  32  encoded instruction.
- err_valid  out  1  one-cycle pulse: the last accepted bundle was rejected.
- err_code  out  2  0 = unsupported opcode; 1 = immediate out of range; 2 = B/J immediate odd.
- busy  out  1  RUN state with FIFO non-empty.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, FIFO empty, write pointer 0. All outputs read 0: in_ready, mem_valid, mem_addr, mem_wdata, err_valid, err_code, busy. Reset mid-transfer discards buffered words; no partial write is issued.
- FSM:
  - IDLE: in_ready=0. start moves to RUN and loads the pointer with base_addr.
  - RUN: in_ready = !fifo_full.
  - start in RUN is honoured only when the FIFO is empty and no input is accepted that cycle; otherwise it is ignored.
  - There is no return to IDLE except by reset.
- Accept: in_valid && in_ready. The encoded word enters the FIFO at the next edge and is visible on mem_wdata the cycle after acceptance (latency 1) if the FIFO was empty.
- Encoding, opcode[6:0] always at [6:0]:
  - R 0110011: funct7→[31:25], Rb→[24:20], Ra→[19:15], funct3→[14:12], Rw→[11:7].
  - LOAD 0000011: imm[11:0]→[31:20], Rb→[19:15] (the base register travels on Rb), funct3, Rw.
  - ADDI 0010011 / JALR 1100111: imm[11:0]→[31:20], Ra→[19:15], funct3, Rw.
  - S 0100011: imm[11:5]→[31:25], Rb→[24:20], Ra→[19:15], funct3, imm[4:0]→[11:7].
  - B 1100011: imm[12]→[31], imm[10:5]→[30:25], Rb, Ra, funct3, imm[4:1]→[11:8], imm[11]→[7].
  - J 1101111: imm[20]→[31], imm[10:1]→[30:21], imm[11]→[20], imm[19:12]→[19:12], Rw.
  - U 0010111: imm[31:12]→[31:12], Rw.
- Range checks:
  - I/S: imm[31:12] must be 0.
  - B: imm[31:13] must be 0.
  - J: imm[31:21] must be 0.
  - U: imm[11:0] must be 0.
  - B/J: imm[0] must be 0.
  - Any violation gives err_code 1. An odd B/J immediate gives code 2, which takes priority over code 1. An unknown opcode gives code 0.
- A rejected bundle is consumed (handshake completes) but is not written. err_valid pulses for 1 cycle after acceptance, and err_code holds until the next error.
- Memory port:
  - mem_valid = FIFO non-empty.
  - mem_addr/mem_wdata are stable while mem_valid && !mem_ready.
  - On mem_valid && mem_ready: pop the FIFO and add 4 to the pointer, modulo 2^ADDR_W (wrap from max to 0 is silent).
- Simultaneous push and pop when full: in_ready is already 0, so no push occurs. When neither full nor empty, push and pop happen in the same cycle and the count is unchanged.

Decomposition:
- Package riscv_isa_pkg: opcode localparams (OP_R, OP_LOAD, OP_ADDI, OP_JALR, OP_B, OP_S, OP_JAL, OP_AUIPC) and err_code constants. The decoder switches to the same package.
- Sub-module instr_word_fifo: synchronous FIFO, width 32, depth FIFO_DEPTH, with full/empty flags.

Test Plan:
- start with base_addr=0x100; ADDI Ra=1, Rw=5, imm=12, funct3=0 → mem_wdata=0x00C08293 at mem_addr=0x100; next word at 0x104.
- R-type Ra=1, Rb=2, Rw=3, funct3=0, funct7=0 → 0x002081B3; with funct7=0x20 → 0x402081B3.
- LOAD Rb=2, Rw=6, funct3=2, imm=8 → 0x00812303. B Ra=1, Rb=2, funct3=0, imm=8 → 0x00208463. JAL Rw=1, imm=2048 → 0x001000EF.
- B-type imm=7 → err_valid pulse with err_code=2, no memory write, pointer unchanged. Opcode 0x7F → err_code=0.
- mem_ready=0 with 3 valid bundles → 2 words buffered and in_ready=0; mem_wdata holds the first word. Raise mem_ready → words drain in order.
- rst_n=0 while 2 words are buffered → next cycle mem_valid=0, in_ready=0, state IDLE. start without reset while the FIFO is non-empty → ignored.
